dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Shares the single DRAM data port between two requesters: port 0 is the CPU data/load-store port; port 1 is the loader/DMA port (UART boot loader or image streamer).
- Sits between the CPU memory-stage interface, the loader, and the DRAM controller.
- Arbitrates one request per cycle using round-robin or CPU-priority.
- Tracks outstanding reads so that in-order DRAM responses are returned to the requester that issued them.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits; byte-enable width is DW/8.
- MAX_OUTST, 4, maximum in-flight reads; power of two, at least 2.
- CPU_PRIO, 0, selects the arbitration policy: 1 means port 0 always wins a conflict; 0 means round-robin.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- p0_valid  in  1  CPU request valid.
- p0_we  in  DW/8  CPU byte write enables; all zero means read.
- p0_addr  in  AW  CPU word address; bits [1:0] are ignored.
- p0_wdata  in  DW  CPU write data.
- p0_ready  out  1  CPU request accepted this cycle.
- p0_rvalid  out  1  CPU read data valid.
- p0_rdata  out  DW  CPU read data.
- p1_valid, p1_we, p1_addr, p1_wdata, p1_ready, p1_rvalid, p1_rdata: same as the p0_* ports, for the loader.
- mem_valid  out  1  request to the DRAM controller.
- mem_we  out  DW/8  forwarded byte enables.
- mem_addr  out  AW  forwarded address, with bits [1:0] forced to 0.
- mem_wdata  out  DW  forwarded write data.
- mem_ready  in  1  DRAM controller accepts the request.
- mem_rvalid  in  1  DRAM read response valid; responses are in order.
- mem_rdata  in  DW  DRAM read data.
- outst  out  $clog2(MAX_OUTST)+1  current number of outstanding reads.
- err_orphan  out  1  sticky flag: a response arrived with no read outstanding.

Behaviour:
- Clocking: one clock domain; clk and rst as named above; reset is synchronous and active-high.
- Reset values: mem_valid=0, p0/p1_ready=0, p0/p1_rvalid=0, p0/p1_rdata=0, outst=0, err_orphan=0. The round-robin pointer resets to port 0 (port 0 has priority first).
- Request path:
  - The grant is combinational from the valid inputs, the round-robin pointer and the tag-FIFO state.
  - mem_* is driven with the granted port's fields.
  - pN_ready = grantN & mem_ready.
  - Zero added latency on the request path.
  - A requester must hold valid and its fields stable until ready; the arbiter does not depend on or check this.
- Grant stickiness:
  - Once mem_valid is asserted with mem_ready=0, the grant is locked to that port until the handshake completes.
  - mem_addr, mem_we and mem_wdata must not change while stalled.
- Round-robin:
  - After each accepted request, the pointer moves to the other port.
  - When only one port is valid, that port is granted regardless of the pointer.
  - If CPU_PRIO=1, port 0 wins every conflict and the pointer is unused.
- Read tracking:
  - Each accepted read (we==0) pushes the owner id (1 bit) into a MAX_OUTST-deep FIFO.
  - Writes push nothing.
  - Each mem_rvalid pops the FIFO head and routes the response to that owner.
- Read-response timing:
  - The response is registered: pN_rvalid and pN_rdata appear one cycle after mem_rvalid.
  - pN_rdata holds its value until the next response to that port.
- FIFO full: when outst==MAX_OUTST, read requests are not granted, but writes are still granted. A blocked read does not block a valid write on the other port.
- Simultaneous push and pop in one cycle: outst is unchanged; the FIFO must support push and pop together even when full.
- Orphan response: mem_rvalid while outst==0 sets err_orphan. That response is dropped (no pN_rvalid), and outst stays at 0. err_orphan clears only on rst.
- Reset mid-operation: all outstanding tags are discarded. DRAM responses that arrive after reset with outst==0 set err_orphan. The integrator must reset the DRAM controller together with this block.

Decomposition:
- Shared package holds:
  - the port-id constants PORT_CPU=0 and PORT_LDR=1;
  - the byte-enable width expression;
  - the request bundle layout (we, addr, wdata).
- One sub-module: tag_fifo. It is a synchronous FIFO, 1 bit wide and MAX_OUTST deep, with push, pop, full, empty and count outputs; count drives outst.

Test Plan:
1. Arbitration and ordering: with round-robin (CPU_PRIO=0) and mem_ready=1, both ports issue continuous reads (p0 to 0x100 and up, p1 to 0x200 and up); the DRAM model returns addr^0xA5A5A5A5 two cycles later. Required: grants alternate p0, p1, p0, …; each port receives only its own data, in order, one cycle after mem_rvalid.
2. CPU priority: with CPU_PRIO=1, the same stimulus as scenario 1. Required: p1_ready stays 0 until p0_valid drops, then p1 is granted the next cycle.
3. Stall lock: p1 writes 0xDEADBEEF to 0x40 while mem_ready is held 0 for 5 cycles, and p0 asserts valid in cycle 2. Required: mem_addr=0x40 and mem_wdata stay stable for all 5 cycles; p0 is granted only after p1's handshake completes.
4. FIFO full: issue 4 reads from p0 with no responses. Required: outst=4, a fifth p0 read is held (p0_ready=0), and a concurrent p1 write with we=4'hF is still accepted. After one mem_rvalid, outst=3 and the fifth read is accepted the next cycle.
5. Orphan response: assert mem_rvalid with data 0x12345678 when outst=0. Required: err_orphan=1 from the next cycle onward, no pN_rvalid, and err_orphan is still 1 after 10 idle cycles.
6. Reset mid-operation: with 3 reads outstanding, pulse rst for 1 cycle. Required: outst=0, all outputs at their reset values, round-robin pointer back at port 0. A subsequent stale mem_rvalid sets err_orphan.

Source files
------------

// File: rtl/dram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dram_arbiter_pkg
//  Description : Shared constants and request-bundle layout for dram_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package dram_arbiter_pkg;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    function automatic int be_width(input int dw);
        return dw / 8;
    endfunction

    // A request bundle is packed MSB-first as {we, addr, wdata}.
    function automatic int req_width(input int aw, input int dw);
        return be_width(dw) + aw + dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dram_arbiter_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tag_fifo
//  Description : 1-bit-wide synchronous FIFO holding the owner of each read.
//  Revision    : 1.0 - initial release
// ============================================================================
module tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     din,
    input  logic                     pop,
    output logic                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int C_PW = $clog2(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [C_PW-1:0]  r_wr_ptr;
    logic [C_PW-1:0]  r_rd_ptr;
    logic [C_PW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (C_PW + 1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes a push.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{C_PW{1'b0}}, w_do_push} - {{C_PW{1'b0}}, w_do_pop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/dram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dram_arbiter
//  Description : Two-port DRAM arbiter (CPU / loader) with in-order read routing.
//  Revision    : 1.0 - initial release
// ============================================================================
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_OUTST = 4,
    parameter int CPU_PRIO  = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        p0_valid,
    input  logic [be_width(DW)-1:0]     p0_we,
    input  logic [AW-1:0]               p0_addr,
    input  logic [DW-1:0]               p0_wdata,
    output logic                        p0_ready,
    output logic                        p0_rvalid,
    output logic [DW-1:0]               p0_rdata,
    input  logic                        p1_valid,
    input  logic [be_width(DW)-1:0]     p1_we,
    input  logic [AW-1:0]               p1_addr,
    input  logic [DW-1:0]               p1_wdata,
    output logic                        p1_ready,
    output logic                        p1_rvalid,
    output logic [DW-1:0]               p1_rdata,
    output logic                        mem_valid,
    output logic [be_width(DW)-1:0]     mem_we,
    output logic [AW-1:0]               mem_addr,
    output logic [DW-1:0]               mem_wdata,
    input  logic                        mem_ready,
    input  logic                        mem_rvalid,
    input  logic [DW-1:0]               mem_rdata,
    output logic [$clog2(MAX_OUTST):0]  outst,
    output logic                        err_orphan
);

    localparam int            C_BW        = be_width(DW);
    localparam int            C_RW        = req_width(AW, DW);
    localparam logic [AW-1:0] C_ADDR_MASK = ~AW'(3);

    logic [C_RW-1:0] w_req0, w_req1, w_req_g;
    logic            w_elig0, w_elig1;
    logic            w_gnt_any, w_gnt_port;
    logic            w_hs, w_push, w_pop;
    logic            w_full, w_empty, w_head;
    logic            r_rr_ptr, r_lock, r_lock_port;
    logic            r_p0_rvalid, r_p1_rvalid, r_err_orphan;
    logic [DW-1:0]   r_p0_rdata, r_p1_rdata;

    assign w_req0  = {p0_we, p0_addr, p0_wdata};
    assign w_req1  = {p1_we, p1_addr, p1_wdata};
    // Reads are held off while the tag FIFO is full; writes always compete.
    assign w_elig0 = p0_valid && !(w_full && (p0_we == '0));
    assign w_elig1 = p1_valid && !(w_full && (p1_we == '0));

    always_comb begin
        w_gnt_any  = 1'b0;
        w_gnt_port = PORT_CPU;
        if (r_lock) begin
            w_gnt_any  = 1'b1;
            w_gnt_port = r_lock_port;
        end else if (w_elig0 && w_elig1) begin
            w_gnt_any  = 1'b1;
            w_gnt_port = (CPU_PRIO != 0) ? PORT_CPU : r_rr_ptr;
        end else if (w_elig0) begin
            w_gnt_any  = 1'b1;
            w_gnt_port = PORT_CPU;
        end else if (w_elig1) begin
            w_gnt_any  = 1'b1;
            w_gnt_port = PORT_LDR;
        end
        if (rst) begin
            w_gnt_any = 1'b0;
        end
    end

    assign w_req_g   = (w_gnt_port == PORT_LDR) ? w_req1 : w_req0;
    assign mem_valid = w_gnt_any;
    assign mem_we    = w_req_g[C_RW-1 -: C_BW];
    assign mem_addr  = w_req_g[DW +: AW] & C_ADDR_MASK;
    assign mem_wdata = w_req_g[DW-1:0];

    assign p0_ready  = w_gnt_any && (w_gnt_port == PORT_CPU) && mem_ready;
    assign p1_ready  = w_gnt_any && (w_gnt_port == PORT_LDR) && mem_ready;

    assign w_hs      = w_gnt_any && mem_ready;
    assign w_push    = w_hs && (mem_we == '0);
    assign w_pop     = mem_rvalid && !w_empty;

    tag_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_gnt_port),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (outst)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= PORT_CPU;
            r_lock       <= 1'b0;
            r_lock_port  <= PORT_CPU;
            r_p0_rvalid  <= 1'b0;
            r_p1_rvalid  <= 1'b0;
            r_p0_rdata   <= '0;
            r_p1_rdata   <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_hs) begin
                r_rr_ptr <= ~w_gnt_port;
            end
            r_lock      <= w_gnt_any && !mem_ready;
            r_lock_port <= w_gnt_port;
            r_p0_rvalid <= w_pop && (w_head == PORT_CPU);
            r_p1_rvalid <= w_pop && (w_head == PORT_LDR);
            if (w_pop && (w_head == PORT_CPU)) begin
                r_p0_rdata <= mem_rdata;
            end
            if (w_pop && (w_head == PORT_LDR)) begin
                r_p1_rdata <= mem_rdata;
            end
            if (mem_rvalid && w_empty) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    assign p0_rvalid  = r_p0_rvalid;
    assign p1_rvalid  = r_p1_rvalid;
    assign p0_rdata   = r_p0_rdata;
    assign p1_rdata   = r_p1_rdata;
    assign err_orphan = r_err_orphan;

endmodule
`default_nettype wire

// File: tb/tb_dram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dram_arbiter
//  Description : Directed bench; instance a is round-robin, instance b CPU-priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_valid, p1_valid;
    logic [3:0]  p0_we, p1_we;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic        mem_ready;
    logic        model_en;
    logic        man_rvalid;
    logic [31:0] man_rdata;

    logic        a_p0_ready, a_p1_ready, a_p0_rvalid, a_p1_rvalid, a_mem_valid, a_err_orphan;
    logic [31:0] a_p0_rdata, a_p1_rdata, a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_we;
    logic [2:0]  a_outst;
    logic        a_mem_rvalid;
    logic [31:0] a_mem_rdata;

    logic        b_p0_ready, b_p1_ready, b_p0_rvalid, b_p1_rvalid, b_mem_valid, b_err_orphan;
    logic [31:0] b_p0_rdata, b_p1_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_we;
    logic [2:0]  b_outst;
    logic        b_mem_rvalid;
    logic [31:0] b_mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dram_arbiter #(.AW(32), .DW(32), .MAX_OUTST(4), .CPU_PRIO(0)) u_a (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ready(a_p0_ready), .p0_rvalid(a_p0_rvalid), .p0_rdata(a_p0_rdata),
        .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ready(a_p1_ready), .p1_rvalid(a_p1_rvalid), .p1_rdata(a_p1_rdata),
        .mem_valid(a_mem_valid), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(a_mem_rvalid), .mem_rdata(a_mem_rdata),
        .outst(a_outst), .err_orphan(a_err_orphan)
    );

    dram_arbiter #(.AW(32), .DW(32), .MAX_OUTST(4), .CPU_PRIO(1)) u_b (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ready(b_p0_ready), .p0_rvalid(b_p0_rvalid), .p0_rdata(b_p0_rdata),
        .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ready(b_p1_ready), .p1_rvalid(b_p1_rvalid), .p1_rdata(b_p1_rdata),
        .mem_valid(b_mem_valid), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(b_mem_rvalid), .mem_rdata(b_mem_rdata),
        .outst(b_outst), .err_orphan(b_err_orphan)
    );

    // DRAM model: read data = addr ^ 0xA5A5A5A5, returned two cycles after acceptance.
    logic        a_s0_v = 1'b0, a_s1_v = 1'b0, b_s0_v = 1'b0, b_s1_v = 1'b0;
    logic [31:0] a_s0_d = '0, a_s1_d = '0, b_s0_d = '0, b_s1_d = '0;

    always @(posedge clk) begin
        if (rst) begin
            a_s0_v <= 1'b0; a_s1_v <= 1'b0; b_s0_v <= 1'b0; b_s1_v <= 1'b0;
        end else begin
            a_s0_v <= a_mem_valid && mem_ready && (a_mem_we == 4'h0);
            a_s0_d <= a_mem_addr ^ 32'hA5A5_A5A5;
            a_s1_v <= a_s0_v;
            a_s1_d <= a_s0_d;
            b_s0_v <= b_mem_valid && mem_ready && (b_mem_we == 4'h0);
            b_s0_d <= b_mem_addr ^ 32'hA5A5_A5A5;
            b_s1_v <= b_s0_v;
            b_s1_d <= b_s0_d;
        end
    end

    assign a_mem_rvalid = model_en ? a_s1_v : man_rvalid;
    assign a_mem_rdata  = model_en ? a_s1_d : man_rdata;
    assign b_mem_rvalid = model_en ? b_s1_v : man_rvalid;
    assign b_mem_rdata  = model_en ? b_s1_d : man_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_valid = 1'b0; p1_valid = 1'b0;
        p0_we = 4'h0; p1_we = 4'h0;
        man_rvalid = 1'b0;
    endtask

    task automatic pulse_reset();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        hs0, hs1;
        int          n0, n1;
        logic [31:0] e0;

        rst = 1'b1; model_en = 1'b0; mem_ready = 1'b0; man_rdata = '0;
        p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
        idle_inputs();
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mem_valid", {31'd0, a_mem_valid}, 32'd0);
        check("rst_p0_ready",  {31'd0, a_p0_ready},  32'd0);
        check("rst_p1_rvalid", {31'd0, a_p1_rvalid}, 32'd0);
        check("rst_p0_rdata",  a_p0_rdata,           32'd0);
        check("rst_outst",     {29'd0, a_outst},     32'd0);
        check("rst_err",       {31'd0, a_err_orphan}, 32'd0);

        // Round-robin with continuous reads on both ports.
        model_en = 1'b1; mem_ready = 1'b1;
        n0 = 0; n1 = 0; hs0 = 1'b0; hs1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n0 += int'(hs0); n1 += int'(hs1);
            p0_valid = 1'b1; p0_we = 4'h0; p0_addr = 32'h100 + 32'(4 * n0);
            p1_valid = 1'b1; p1_we = 4'h0; p1_addr = 32'h200 + 32'(4 * n1);
            @(negedge clk);
            check("rr_p0_ready", {31'd0, a_p0_ready}, {31'd0, (i % 2) == 0});
            check("rr_p1_ready", {31'd0, a_p1_ready}, {31'd0, (i % 2) == 1});
            check("rr_mem_addr", a_mem_addr,
                  ((i % 2) == 0 ? 32'h100 : 32'h200) + 32'(4 * (i / 2)));
            check("rr_p0_rvalid", {31'd0, a_p0_rvalid}, {31'd0, i >= 3 && ((i - 3) % 2) == 0});
            check("rr_p1_rvalid", {31'd0, a_p1_rvalid}, {31'd0, i >= 4 && ((i - 4) % 2) == 0});
            if (i >= 3 && ((i - 3) % 2) == 0) begin
                e0 = (32'h100 + 32'(4 * ((i - 3) / 2))) ^ 32'hA5A5_A5A5;
                check("rr_p0_rdata", a_p0_rdata, e0);
            end
            if (i >= 4 && ((i - 4) % 2) == 0) begin
                e0 = (32'h200 + 32'(4 * ((i - 4) / 2))) ^ 32'hA5A5_A5A5;
                check("rr_p1_rdata", a_p1_rdata, e0);
            end
            hs0 = a_p0_ready; hs1 = a_p1_ready;
        end
        step();
        idle_inputs();
        repeat (4) step();
        pulse_reset();

        // CPU priority: same stimulus, observed on instance b.
        n0 = 0; n1 = 0; hs0 = 1'b0; hs1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            n0 += int'(hs0); n1 += int'(hs1);
            p0_valid = (i < 6); p0_we = 4'h0; p0_addr = 32'h100 + 32'(4 * n0);
            p1_valid = 1'b1;    p1_we = 4'h0; p1_addr = 32'h200 + 32'(4 * n1);
            @(negedge clk);
            check("pr_p0_ready", {31'd0, b_p0_ready}, {31'd0, i < 6});
            check("pr_p1_ready", {31'd0, b_p1_ready}, {31'd0, i >= 6});
            check("pr_mem_addr", b_mem_addr,
                  (i < 6) ? 32'h100 + 32'(4 * i) : 32'h200 + 32'(4 * (i - 6)));
            check("pr_p0_rvalid", {31'd0, b_p0_rvalid}, {31'd0, i >= 3});
            if (i >= 3) begin
                check("pr_p0_rdata", b_p0_rdata, (32'h100 + 32'(4 * (i - 3))) ^ 32'hA5A5_A5A5);
            end
            hs0 = b_p0_ready; hs1 = b_p1_ready;
        end
        step();
        idle_inputs();
        repeat (4) step();
        pulse_reset();

        // Stall lock: p1 write held off by mem_ready=0, p0 arrives mid-stall.
        model_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            mem_ready = (i >= 5);
            p1_valid = (i <= 5); p1_we = 4'hF; p1_addr = 32'h40; p1_wdata = 32'hDEAD_BEEF;
            p0_valid = (i >= 1); p0_we = 4'h0; p0_addr = 32'h80;
            @(negedge clk);
            if (i <= 5) begin
                check("stall_mem_addr",  a_mem_addr,  32'h40);
                check("stall_mem_wdata", a_mem_wdata, 32'hDEAD_BEEF);
                check("stall_p0_ready",  {31'd0, a_p0_ready}, 32'd0);
                check("stall_p1_ready",  {31'd0, a_p1_ready}, {31'd0, i == 5});
            end else begin
                check("stall_p0_grant",  {31'd0, a_p0_ready}, 32'd1);
                check("stall_p0_addr",   a_mem_addr, 32'h80);
                check("stall_p0_we",     {28'd0, a_mem_we}, 32'd0);
            end
        end
        step();
        idle_inputs();
        @(negedge clk);
        check("stall_outst", {29'd0, a_outst}, 32'd1);
        pulse_reset();

        // FIFO full: four reads outstanding, fifth held, write still passes.
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            p0_valid = 1'b1; p0_we = 4'h0; p0_addr = 32'h300 + 32'(4 * i);
            @(negedge clk);
            check("full_fill_ready", {31'd0, a_p0_ready}, 32'd1);
            check("full_fill_outst", {29'd0, a_outst},    32'(i));
        end
        step();
        p0_addr = 32'h310;
        p1_valid = 1'b1; p1_we = 4'hF; p1_addr = 32'h50; p1_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("full_outst",      {29'd0, a_outst},    32'd4);
        check("full_p0_blocked", {31'd0, a_p0_ready}, 32'd0);
        check("full_p1_write",   {31'd0, a_p1_ready}, 32'd1);
        check("full_mem_we",     {28'd0, a_mem_we},   32'hF);
        check("full_mem_addr",   a_mem_addr,          32'h50);
        step();
        p1_valid = 1'b0; p1_we = 4'h0;
        man_rvalid = 1'b1; man_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        check("full_still_blocked", {31'd0, a_p0_ready},  32'd0);
        check("full_no_req",        {31'd0, a_mem_valid}, 32'd0);
        check("full_outst_hold",    {29'd0, a_outst},     32'd4);
        step();
        man_rvalid = 1'b0;
        @(negedge clk);
        check("full_outst_pop",  {29'd0, a_outst},     32'd3);
        check("full_p0_accept",  {31'd0, a_p0_ready},  32'd1);
        check("full_p0_addr",    a_mem_addr,           32'h310);
        check("full_p0_rvalid",  {31'd0, a_p0_rvalid}, 32'd1);
        check("full_p0_rdata",   a_p0_rdata,           32'h0BAD_F00D);
        check("full_p1_rvalid",  {31'd0, a_p1_rvalid}, 32'd0);
        step();
        idle_inputs();
        @(negedge clk);
        check("full_outst_refill", {29'd0, a_outst}, 32'd4);
        pulse_reset();

        // Orphan response.
        step();
        man_rvalid = 1'b1; man_rdata = 32'h1234_5678;
        @(negedge clk);
        check("orph_err_before", {31'd0, a_err_orphan}, 32'd0);
        step();
        man_rvalid = 1'b0;
        @(negedge clk);
        check("orph_err_set",   {31'd0, a_err_orphan}, 32'd1);
        check("orph_p0_rvalid", {31'd0, a_p0_rvalid},  32'd0);
        check("orph_p1_rvalid", {31'd0, a_p1_rvalid},  32'd0);
        check("orph_outst",     {29'd0, a_outst},      32'd0);
        repeat (10) step();
        @(negedge clk);
        check("orph_err_sticky", {31'd0, a_err_orphan}, 32'd1);

        // Reset with three reads outstanding; pointer left at port 1 beforehand.
        for (int i = 0; i < 3; i++) begin
            step();
            p0_valid = 1'b1; p0_we = 4'h0; p0_addr = 32'h400 + 32'(4 * i);
        end
        step();
        idle_inputs();
        @(negedge clk);
        check("mid_outst_pre", {29'd0, a_outst}, 32'd3);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_mem_valid", {31'd0, a_mem_valid}, 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid_outst",     {29'd0, a_outst},      32'd0);
        check("mid_err",       {31'd0, a_err_orphan}, 32'd0);
        check("mid_mem_valid", {31'd0, a_mem_valid},  32'd0);
        check("mid_p0_rvalid", {31'd0, a_p0_rvalid},  32'd0);
        check("mid_p0_rdata",  a_p0_rdata,            32'd0);
        step();
        man_rvalid = 1'b1; man_rdata = 32'h0000_0408 ^ 32'hA5A5_A5A5;
        step();
        man_rvalid = 1'b0;
        @(negedge clk);
        check("mid_stale_err",    {31'd0, a_err_orphan}, 32'd1);
        check("mid_stale_rvalid", {31'd0, a_p0_rvalid},  32'd0);
        step();
        p0_valid = 1'b1; p0_we = 4'h0; p0_addr = 32'h500;
        p1_valid = 1'b1; p1_we = 4'h0; p1_addr = 32'h600;
        @(negedge clk);
        check("mid_ptr_p0", {31'd0, a_p0_ready}, 32'd1);
        check("mid_ptr_p1", {31'd0, a_p1_ready}, 32'd0);
        step();
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
